// File: rtl/mc_bus_pkg.sv
// Shared types and constants for the multicast bus scheduler and its arbiter.
// State enum, channel indices and default widths live here.
package mc_bus_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAG_W  = 6;

  localparam logic [1:0] CH_W = 2'd0;
  localparam logic [1:0] CH_I = 2'd1;
  localparam logic [1:0] CH_P = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Round-robin successor over the three channels (weight -> ifmap -> psum -> weight).
  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == CH_P) ? CH_W : ch + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-request round-robin arbiter: i_ptr names the highest-priority request,
// o_gnt is one-hot (or zero when nothing is requested).
module rr_arbiter3
  import mc_bus_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_gnt
);

  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  always_comb begin
    // An out-of-range pointer falls back to weight-first.
    w_c0  = (i_ptr == 2'd3) ? CH_W : i_ptr;
    w_c1  = next_ch(w_c0);
    w_c2  = next_ch(w_c1);
    o_gnt = 3'b000;
    if (i_req[w_c0]) begin
      o_gnt[w_c0] = 1'b1;
    end else if (i_req[w_c1]) begin
      o_gnt[w_c1] = 1'b1;
    end else if (i_req[w_c2]) begin
      o_gnt[w_c2] = 1'b1;
    end
  end

endmodule

// File: rtl/mc_bus_scheduler.sv
// Round-robin burst sequencer for the shared multicast bus (weight/ifmap/psum).
// Optional stall abort is enabled by defining MC_BUS_TIMEOUT_EN.
//
// Handshake: a requester word moves when i_*_valid & o_*_ready are both high at a
// clock edge; a bus word moves when o_bus_enable & i_bus_ready are both high.
// ready depends combinationally on valid; valid never depends on ready.
module mc_bus_scheduler
  import mc_bus_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TAG_W       = DEF_TAG_W,
  parameter int BURST_MAX   = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_w_valid,
  input  logic [TAG_W-1:0]  i_w_tag,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic              i_w_last,
  output logic              o_w_ready,
  input  logic              i_i_valid,
  input  logic [TAG_W-1:0]  i_i_tag,
  input  logic [DATA_W-1:0] i_i_data,
  input  logic              i_i_last,
  output logic              o_i_ready,
  input  logic              i_p_valid,
  input  logic [TAG_W-1:0]  i_p_tag,
  input  logic [DATA_W-1:0] i_p_data,
  input  logic              i_p_last,
  output logic              o_p_ready,
  output logic              o_bus_enable,
  output logic [TAG_W-1:0]  o_bus_tag,
  output logic [DATA_W-1:0] o_bus_value,
  input  logic              i_bus_ready,
  output logic              o_weight_wea,
  output logic              o_ifmap_wea,
  output logic              o_psum_wea,
  output logic              o_busy,
  output logic              o_err_timeout,
  output logic [1:0]        o_dbg_state
);

  localparam int BEAT_W = $clog2(BURST_MAX + 1);
  localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(BURST_MAX);

  state_e r_state;
  state_e w_next_state;
  logic [1:0] r_ptr;
  logic [1:0] r_gch;
  logic [BEAT_W-1:0] r_beat;
  logic r_closing;
  logic [TAG_W-1:0] r_tag;
  logic [DATA_W-1:0] r_data;

  logic [2:0] w_valid;
  logic [2:0] w_last;
  logic [TAG_W-1:0] w_tag [3];
  logic [DATA_W-1:0] w_data [3];
  logic [2:0] w_gnt;
  logic [2:0] w_ready;
  logic [1:0] w_win_ch;
  logic [1:0] w_load_ch;
  logic w_load;
  logic w_first;
  logic w_done;
  logic w_abort;
  logic [BEAT_W-1:0] w_beat_nxt;

  assign w_valid = {i_p_valid, i_i_valid, i_w_valid};
  assign w_last  = {i_p_last, i_i_last, i_w_last};
  assign w_tag[CH_W]  = i_w_tag;
  assign w_tag[CH_I]  = i_i_tag;
  assign w_tag[CH_P]  = i_p_tag;
  assign w_data[CH_W] = i_w_data;
  assign w_data[CH_I] = i_i_data;
  assign w_data[CH_P] = i_p_data;

  rr_arbiter3 u_arb (
    .i_req (w_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  assign w_win_ch   = w_gnt[2] ? CH_P : (w_gnt[1] ? CH_I : CH_W);
  assign w_beat_nxt = w_first ? BEAT_W'(1) : r_beat + BEAT_W'(1);

  always_comb begin
    w_next_state = r_state;
    w_ready      = 3'b000;
    w_load       = 1'b0;
    w_first      = 1'b0;
    w_done       = 1'b0;
    w_load_ch    = r_gch;
    unique case (r_state)
      IDLE: begin
        if (|w_valid) begin
          w_load_ch    = w_win_ch;
          w_ready      = w_gnt;
          w_load       = 1'b1;
          w_first      = 1'b1;
          w_next_state = XFER;
        end
      end
      XFER: begin
        if (i_bus_ready) begin
          if (r_closing) begin
            w_done       = 1'b1;
            w_next_state = IDLE;
          end else if (w_valid[r_gch]) begin
            // Refill the output register in the same cycle the held word leaves.
            w_ready[r_gch] = 1'b1;
            w_load         = 1'b1;
          end else begin
            w_next_state = WAIT;
          end
        end else if (w_abort) begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end
      end
      WAIT: begin
        if (w_valid[r_gch]) begin
          w_ready[r_gch] = 1'b1;
          w_load         = 1'b1;
          w_next_state   = XFER;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_ptr     <= CH_W;
      r_gch     <= CH_W;
      r_beat    <= '0;
      r_closing <= 1'b0;
      r_tag     <= '0;
      r_data    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_gch     <= w_load_ch;
        r_beat    <= w_beat_nxt;
        r_closing <= w_last[w_load_ch] | (w_beat_nxt == BEAT_LIMIT);
        r_tag     <= w_tag[w_load_ch];
        r_data    <= w_data[w_load_ch];
      end
      if (w_done) begin
        r_ptr     <= next_ch(r_gch);
        r_beat    <= '0;
        r_closing <= 1'b0;
      end
    end
  end

`ifdef MC_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_tocnt;
  logic r_err;

  // Abort on the TIMEOUT_CYC-th consecutive stalled XFER cycle.
  assign w_abort = (r_state == XFER) && !i_bus_ready &&
                   (r_tocnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tocnt <= '0;
      r_err   <= 1'b0;
    end else begin
      if ((r_state == XFER) && !i_bus_ready && !w_abort) begin
        r_tocnt <= r_tocnt + TO_W'(1);
      end else begin
        r_tocnt <= '0;
      end
      if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err_timeout = r_err;
`else
  assign w_abort       = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  assign o_w_ready    = w_ready[CH_W];
  assign o_i_ready    = w_ready[CH_I];
  assign o_p_ready    = w_ready[CH_P];
  assign o_bus_enable = (r_state == XFER);
  assign o_bus_tag    = r_tag;
  assign o_bus_value  = r_data;
  assign o_busy       = (r_state != IDLE);
  assign o_weight_wea = o_busy && (r_gch == CH_W);
  assign o_ifmap_wea  = o_busy && (r_gch == CH_I);
  assign o_psum_wea   = o_busy && (r_gch == CH_P);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mc_bus_scheduler.sv
// Bench for mc_bus_scheduler: round-robin vector table, queue-driven scenarios checked
// against a burst-level model, plus reset and stall/abort sequences.
module tb_mc_bus_scheduler;

  localparam int DATA_W    = 32;
  localparam int TAG_W     = 6;
  localparam int BURST_MAX = 16;
`ifdef MC_BUS_TIMEOUT_EN
  localparam int EXP_STALL = 8;
  localparam int EXP_ERR   = 1;
  localparam int STALL_LEN = 6;
`else
  localparam int EXP_STALL = 20;
  localparam int EXP_ERR   = 0;
  localparam int STALL_LEN = 10;
`endif

  typedef struct packed {
    logic [1:0]        ch;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              last;
  } word_t;

  typedef struct {
    logic [2:0]        mask;
    int                exp_ch;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk;
  logic rstn;
  logic [2:0] d_valid;
  logic [2:0] d_last;
  logic [TAG_W-1:0] d_tag [3];
  logic [DATA_W-1:0] d_data [3];
  logic d_bus_ready;
  logic w_rdy, i_rdy, p_rdy;
  logic bus_enable;
  logic [TAG_W-1:0] bus_tag;
  logic [DATA_W-1:0] bus_value;
  logic weight_wea, ifmap_wea, psum_wea;
  logic busy, err_timeout;
  logic [1:0] dbg_state;
  logic [2:0] rdy;
  logic [2:0] wea;

  assign rdy = {p_rdy, i_rdy, w_rdy};
  assign wea = {psum_wea, ifmap_wea, weight_wea};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mc_bus_scheduler #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .BURST_MAX(BURST_MAX), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .i_w_valid(d_valid[0]), .i_w_tag(d_tag[0]), .i_w_data(d_data[0]), .i_w_last(d_last[0]), .o_w_ready(w_rdy),
    .i_i_valid(d_valid[1]), .i_i_tag(d_tag[1]), .i_i_data(d_data[1]), .i_i_last(d_last[1]), .o_i_ready(i_rdy),
    .i_p_valid(d_valid[2]), .i_p_tag(d_tag[2]), .i_p_data(d_data[2]), .i_p_last(d_last[2]), .o_p_ready(p_rdy),
    .o_bus_enable(bus_enable), .o_bus_tag(bus_tag), .o_bus_value(bus_value), .i_bus_ready(d_bus_ready),
    .o_weight_wea(weight_wea), .o_ifmap_wea(ifmap_wea), .o_psum_wea(psum_wea),
    .o_busy(busy), .o_err_timeout(err_timeout), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  word_t src_q [3][$];
  word_t exp_q[$];
  logic exp_first_q[$];
  int m_ptr = 0;
  int cyc = 0;
  int last_xfer = -1;
  int n_xfer = 0;
  int stall_left = 0;
  logic prev_stall = 1'b0;
  logic [TAG_W-1:0] prev_tag;
  logic [DATA_W-1:0] prev_value;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    d_valid = 3'b000;
    d_last  = 3'b000;
    d_bus_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      d_tag[c]  = '0;
      d_data[c] = '0;
    end
  endtask

  task automatic flush_queues();
    for (int c = 0; c < 3; c++) src_q[c].delete();
    exp_q.delete();
    exp_first_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_ptr = 0;
    flush_queues();
  endtask

  task automatic add_burst(input int ch, input int n, input int last_pct);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.ch   = 2'(ch);
      w.tag  = TAG_W'($urandom_range(0, 63));
      w.data = $urandom;
      w.last = (k == n - 1) || ($urandom_range(0, 99) < last_pct);
      src_q[ch].push_back(w);
    end
  endtask

  // Burst-level model: walk the pending lists, granting round-robin over the
  // non-empty ones, each grant ending at last or after BURST_MAX words.
  task automatic build_model();
    word_t mq [3][$];
    word_t w;
    int ch;
    int n;
    for (int c = 0; c < 3; c++) mq[c] = src_q[c];
    while (mq[0].size() + mq[1].size() + mq[2].size() > 0) begin
      ch = -1;
      for (int k = 0; k < 3; k++)
        if (ch < 0 && mq[(m_ptr + k) % 3].size() > 0) ch = (m_ptr + k) % 3;
      n = 0;
      do begin
        w = mq[ch].pop_front();
        exp_q.push_back(w);
        exp_first_q.push_back(n == 0);
        n++;
      end while (!w.last && n < BURST_MAX && mq[ch].size() > 0);
      m_ptr = (ch + 1) % 3;
    end
  endtask

  // One clock: present queue heads, pick bus_ready, check outputs, pop accepted words.
  task automatic cycle(input int ready_pct, input bit chk_gap);
    word_t h;
    word_t e;
    logic ef;
    logic legal;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      if (src_q[c].size() > 0) begin
        h = src_q[c][0];
        d_valid[c] = 1'b1;
        d_tag[c]   = h.tag;
        d_data[c]  = h.data;
        d_last[c]  = h.last;
      end else begin
        d_valid[c] = 1'b0;
        d_last[c]  = 1'b0;
      end
    end
    if (stall_left > 0) begin
      d_bus_ready = 1'b0;
      stall_left--;
    end else begin
      d_bus_ready = ($urandom_range(0, 99) < ready_pct);
    end
    #1;
    legal = ($countones(rdy) <= 1) && ((rdy & ~d_valid) == 3'b000);
    check("ready_legal", legal, 1);
    if (bus_enable && !d_bus_ready) check("stall_no_ready", rdy, 0);
    if (prev_stall)
      check("stall_hold", {bus_enable, bus_tag, bus_value}, {1'b1, prev_tag, prev_value});
    prev_stall = bus_enable && !d_bus_ready;
    prev_tag   = bus_tag;
    prev_value = bus_value;
    if (bus_enable && d_bus_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_word", 1, 0);
      end else begin
        e  = exp_q.pop_front();
        ef = exp_first_q.pop_front();
        check("bus_word", {wea, bus_tag, bus_value}, {3'b001 << e.ch, e.tag, e.data});
        if (chk_gap && last_xfer >= 0) check("bus_gap", cyc - last_xfer, ef ? 2 : 1);
      end
      last_xfer = cyc;
      n_xfer++;
    end
    @(posedge clk);
    cyc++;
    for (int c = 0; c < 3; c++)
      if (rdy[c] && d_valid[c]) void'(src_q[c].pop_front());
  endtask

  task automatic run(input int ready_pct, input bit chk_gap, input int stall_after);
    int budget;
    bit stalled;
    budget = 3000;
    stalled = 1'b0;
    build_model();
    last_xfer = -1;
    n_xfer = 0;
    prev_stall = 1'b0;
    while (exp_q.size() > 0 && budget > 0) begin
      if (stall_after >= 0 && !stalled && n_xfer == stall_after) begin
        stall_left = STALL_LEN;
        stalled = 1'b1;
      end
      cycle(ready_pct, chk_gap);
      budget--;
    end
    check("drain_remaining", exp_q.size(), 0);
    exp_q.delete();
    exp_first_q.delete();
    @(negedge clk);
    d_valid = 3'b000;
    prev_stall = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl [12];
  int cnt;
  bit found;

  initial begin
    // Round-robin table from a fresh reset; every word is a single-word burst.
    tbl[0]  = '{3'b111, 0, 6'd5,  32'hDEADBEEF};
    tbl[1]  = '{3'b111, 1, 6'd10, 32'h1000_0000};
    tbl[2]  = '{3'b111, 2, 6'd20, 32'h2000_0000};
    tbl[3]  = '{3'b101, 0, 6'd30, 32'h3000_0000};
    tbl[4]  = '{3'b101, 2, 6'd40, 32'h4000_0000};
    tbl[5]  = '{3'b010, 1, 6'd50, 32'h5000_0000};
    tbl[6]  = '{3'b001, 0, 6'd1,  32'h6000_0000};
    tbl[7]  = '{3'b110, 1, 6'd11, 32'h7000_0000};
    tbl[8]  = '{3'b011, 0, 6'd21, 32'h8000_0000};
    tbl[9]  = '{3'b100, 2, 6'd31, 32'h9000_0000};
    tbl[10] = '{3'b110, 1, 6'd41, 32'hA000_0000};
    tbl[11] = '{3'b011, 0, 6'd51, 32'hB000_0000};

    rstn = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          {bus_enable, bus_tag, bus_value, wea, busy, err_timeout, rdy, dbg_state}, 0);
    rstn = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        d_valid[c] = tbl[i].mask[c];
        d_tag[c]   = tbl[i].tag + TAG_W'(c);
        d_data[c]  = tbl[i].data + DATA_W'(c);
        d_last[c]  = 1'b1;
      end
      d_bus_ready = 1'b1;
      #1;
      check("rr_ready", rdy, 3'b001 << tbl[i].exp_ch);
      check("rr_idle", {bus_enable, busy}, 0);
      @(negedge clk);
      d_valid = 3'b000;
      #1;
      check("rr_word", {bus_enable, wea, bus_tag, bus_value},
            {1'b1, 3'b001 << tbl[i].exp_ch, tbl[i].tag + TAG_W'(tbl[i].exp_ch),
             tbl[i].data + DATA_W'(tbl[i].exp_ch)});
    end

    // Three 2-word bursts: order weight, ifmap, psum with one idle cycle between.
    do_reset();
    for (int c = 0; c < 3; c++) add_burst(c, 2, 0);
    run(100, 1'b1, -1);

    // 20-word ifmap stream is split into 16 + 4.
    add_burst(1, 20, 0);
    run(100, 1'b1, -1);

    // bus_ready held low mid-burst.
    add_burst(0, 6, 0);
    run(100, 1'b0, 2);
    check("no_err_after_stall", err_timeout, 0);

    // Randomised traffic against the model.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) add_burst(c, $urandom_range(0, 25), 20);
      run(75, 1'b0, -1);
    end

    // Reset in the middle of an ifmap burst, with the pointer away from weight.
    add_burst(0, 1, 0);
    run(100, 1'b0, -1);
    add_burst(1, 6, 0);
    build_model();
    repeat (4) cycle(100, 1'b0);
    @(negedge clk);
    #3;
    rstn = 1'b0;
    d_valid = 3'b000;
    #1;
    check("async_reset", {bus_enable, bus_tag, bus_value, wea, busy, err_timeout, rdy, dbg_state}, 0);
    flush_queues();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_ptr = 0;
    for (int c = 0; c < 3; c++) add_burst(c, 1, 0);
    run(100, 1'b1, -1);

    // bus_ready stuck low with weight and ifmap pending.
    do_reset();
    @(negedge clk);
    d_valid = 3'b011;
    d_last  = 3'b111;
    d_tag[0] = 6'd7;
    d_tag[1] = 6'd9;
    d_data[0] = 32'h0000_0777;
    d_data[1] = 32'h0000_0999;
    d_bus_ready = 1'b0;
    #1;
    check("stuck_accept", rdy, 3'b001);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      d_valid[0] = 1'b0;
      #1;
      if (bus_enable && bus_tag == 6'd7) cnt++;
      else break;
    end
    check("stall_cycles", cnt, EXP_STALL);
    check("err_flag", err_timeout, EXP_ERR);
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      d_bus_ready = 1'b1;
      #1;
      if (bus_enable && bus_tag == 6'd9) begin
        found = 1'b1;
        check("next_grant", {wea, bus_value}, {3'b010, 32'h0000_0999});
        break;
      end
    end
    check("next_grant_seen", found, 1);
    @(negedge clk);
    d_valid = 3'b000;
    repeat (3) @(negedge clk);
    check("err_sticky", err_timeout, EXP_ERR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d errors", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mc_bus_scheduler.md
# mc_bus_scheduler

Sequencer and arbiter for the shared multicast data bus feeding the PE array's per-PE multicast controllers. Three host-side requesters (weight, ifmap, psum) each present tagged 32-bit words. The block grants the bus round-robin in bursts and drives bus enable, tag, value and the one-hot write-enable class toward the array. It honours the aggregated bus ready returned by the targeted multicast controllers.

## Interface
- DATA_W, 32, bus value width
- TAG_W, 6, tag width (matches PE ID width)
- BURST_MAX, 16, max words per grant (≥1)
- TIMEOUT_CYC, 255, stall cycles before abort (used only with MC_BUS_TIMEOUT_EN)

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- {w,i,p}_valid  in  1  requester word valid (weight/ifmap/psum)
- {w,i,p}_tag  in  TAG_W  destination tag of word
- {w,i,p}_data  in  DATA_W  word value
- {w,i,p}_last  in  1  final word of requester's burst
- {w,i,p}_ready  out  1  word accepted this cycle when valid&ready
- bus_enable  out  1  bus word valid
- bus_tag  out  TAG_W  tag on bus
- bus_value  out  DATA_W  value on bus
- bus_ready  in  1  targeted multicast controllers ready
- weight_wea, ifmap_wea, psum_wea  out  1  one-hot class of granted channel
- busy  out  1  state ≠ IDLE
- err_timeout  out  1  sticky abort flag

## Operation
- States: IDLE, XFER (word held, bus_enable=1), WAIT (grant held, output register empty).
- IDLE: if any valid, the winner is chosen combinationally by round-robin. The winner's ready=1, its word is captured into the output register, beat=1 → XFER. No valid → stay.
- Round-robin order weight→ifmap→psum. Pointer starts at weight after reset. On burst end, pointer = channel after granted one.
- XFER, bus_ready=1: word consumed. If closing → IDLE. Else if granted valid → ready=1, load next word, beat+1, stay XFER. Else → WAIT.
- XFER, bus_ready=0: hold all bus outputs stable. No ready asserted.
- WAIT: bus_enable=0. Granted valid → load, beat+1 → XFER. Other requesters never granted.
- closing flag is set when the loaded word has last=1 or beat==BURST_MAX. Once set, no further words are accepted in that grant.
- Tag may change per word within a burst. bus_tag/bus_value are taken from the captured word.
- *_wea: one-hot of granted channel while state ≠ IDLE, else all 0.
- Non-granted ready always 0. At most one ready high per cycle.

## Timing
- Reset: all outputs 0, state IDLE, pointer=weight, beat=0, closing=0, err_timeout=0.
- Accept-to-bus latency: 1 cycle, since word accepted at edge N drives bus from N+1.
- Back-to-back throughput: 1 word/cycle within a grant when bus_ready stays high.
- Burst end costs one IDLE cycle with bus_enable=0 before the next grant.
- Reset mid-burst: held word discarded, no partial state survives.
- BURST_MAX=1: every word closes its grant. Strict alternation when several requesters are valid.

## Configuration
- MC_BUS_TIMEOUT_EN defined:
  - A counter counts consecutive XFER cycles with bus_ready=0.
  - When it reaches TIMEOUT_CYC, the held word is dropped, err_timeout is set (sticky until reset), the pointer advances and state → IDLE.
  - The counter clears on any bus_ready=1.
- Undefined: no counter. XFER waits indefinitely. err_timeout is tied 0.

## Structure
- Shared package mc_bus_pkg: state enum (IDLE/XFER/WAIT), channel index constants CH_W=0, CH_I=1, CH_P=2, default TAG_W/DATA_W.
- Sub-module rr_arbiter3: 3-request round-robin with pointer input, one-hot grant output. It is reused by later global-buffer ports.

## Test plan
- Single weight word, tag=5, data=0xDEADBEEF, last=1, bus_ready=1 → bus_enable one cycle with tag 5, weight_wea=1, then IDLE.
- All three valid, 2-word bursts each, bus_ready=1 → grant order weight, ifmap, psum. One idle cycle between bursts.
- Ifmap burst of 20 words, no last, BURST_MAX=16 → 16 words, grant released, remaining 4 sent in a later grant.
- bus_ready low 10 cycles mid-burst → bus_tag/bus_value stable, no ready asserted, transfer resumes intact.
- With MC_BUS_TIMEOUT_EN, TIMEOUT_CYC=8, bus_ready stuck low → abort after 8 stall cycles, err_timeout=1, next requester granted.
- rstn pulsed mid-burst → all outputs 0 asynchronously, next grant starts from weight.
